// File: rtl/ar_arb21.sv
// rtl/ar_arb21.sv - two-requester round-robin burst arbiter driving a 2:1 output mux
//
// Purpose:
//   Shares one valid/ready output channel between requester 0 and requester 1.
//   A grant lasts for a whole burst. It is released early when the burst's last
//   beat fires. It is also released after MAX_BURST beats, so neither side can
//   starve the other. A grant is also released when the owner drops its request.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req[1:0]   req[i] high: requester i has a valid beat on din<i>
//   last[1:0]  last[i] high: current beat of requester i ends its burst
//   din0/din1  requester data, W bits each
//   out_ready  downstream accepts the beat this cycle
//   out_valid  beat on dout is valid
//   dout       muxed data (din1 when sel=1, else din0)
//   gnt[1:0]   one-hot grant, 2'b00 when idle
//   sel        mux select, 1 only while requester 1 owns the channel

module ar_arb21 #(
  parameter int W         = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [1:0]   last,
  input  logic [W-1:0] din0,
  input  logic [W-1:0] din1,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] dout,
  output logic [1:0]   gnt,
  output logic         sel
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_ptr;   // index of the most recent owner; the opposite side wins a tie
  logic [7:0] r_cnt;   // beats already fired within the current grant

  logic w_sel;
  logic w_own_req;
  logic w_oth_req;
  logic w_fire;
  logic w_cnt_max;
  logic w_release;

  // Every output is decoded from the state. out_valid also follows the owner's request.
  assign w_sel     = (r_state == S_OWN1);
  assign w_own_req = req[w_sel];
  assign w_oth_req = req[~w_sel];
  assign sel       = w_sel;
  assign gnt       = (r_state == S_OWN0) ? 2'b01 :
                     (r_state == S_OWN1) ? 2'b10 : 2'b00;
  assign dout      = w_sel ? din1 : din0;
  assign out_valid = (r_state != S_IDLE) & w_own_req;
  assign w_fire    = out_valid & out_ready;
  assign w_cnt_max = (r_cnt == 8'(MAX_BURST - 1));

  // When the owner abandons, its request is low. out_valid is then low, so no
  // beat fires. The abandon term is kept separate from the fire terms.
  assign w_release = (w_fire & (last[w_sel] | w_cnt_max)) | ~w_own_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= 8'd0;
          case (req)
            2'b01:   r_state <= S_OWN0;
            2'b10:   r_state <= S_OWN1;
            2'b11:   r_state <= r_ptr ? S_OWN0 : S_OWN1;
            default: r_state <= S_IDLE;
          endcase
        end
        S_OWN0, S_OWN1: begin
          if (w_release) begin
            r_ptr <= w_sel;
            r_cnt <= 8'd0;
            // The other side is served first. The owner is re-granted only if
            // nobody else waits. w_own_req is low whenever the release was an abandon.
            if (w_oth_req)
              r_state <= w_sel ? S_OWN0 : S_OWN1;
            else if (w_own_req)
              r_state <= r_state;
            else
              r_state <= S_IDLE;
          end else if (w_fire) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ar_arb21.sv
// tb/tb_ar_arb21.sv - directed self-checking bench for ar_arb21

module tb_ar_arb21;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [1:0] last;
  logic [7:0] din0;
  logic [7:0] din1;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] dout;
  logic [1:0] gnt;
  logic       sel;

  int n_checks = 0;
  int n_errors = 0;

  ar_arb21 #(.W(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .din0      (din0),
    .din1      (din1),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .dout      (dout),
    .gnt       (gnt),
    .sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Outputs are sampled mid-cycle, away from the rising edge.
  task automatic expect_out(input string tag, input logic [1:0] g, input logic s,
                            input logic v, input logic [7:0] d);
    #1;
    check({tag, ".gnt"},       32'(gnt),       32'(g));
    check({tag, ".sel"},       32'(sel),       32'(s));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".dout"},      32'(dout),      32'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 2'b00; last = 2'b00;
    din0 = 8'h11; din1 = 8'h22; out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    expect_out("reset", 2'b00, 1'b0, 1'b0, 8'h11);

    // t1: only requester 0, every beat is last -> re-granted back to back.
    req = 2'b01; last = 2'b01;
    expect_out("t1_idle", 2'b00, 1'b0, 1'b0, 8'h11);
    tick();
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("t1_own0_%0d", k), 2'b01, 1'b0, 1'b1, 8'h11);
      tick();
    end
    req = 2'b00; last = 2'b00;
    expect_out("t1_drop", 2'b01, 1'b0, 1'b0, 8'h11);
    tick();
    expect_out("t1_idle2", 2'b00, 1'b0, 1'b0, 8'h11);

    // t2: tie from reset, 4-beat bursts alternate. The 4th beat also carries last.
    do_reset();
    din0 = 8'hA0; din1 = 8'hB1; req = 2'b11; last = 2'b00;
    expect_out("t2_idle", 2'b00, 1'b0, 1'b0, 8'hA0);
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) last = 2'b01;
      expect_out($sformatf("t2_own0_%0d", k), 2'b01, 1'b0, 1'b1, 8'hA0);
      tick();
    end
    last = 2'b00;
    for (int k = 0; k < 4; k++) begin
      expect_out($sformatf("t2_own1_%0d", k), 2'b10, 1'b1, 1'b1, 8'hB1);
      tick();
    end
    expect_out("t2_back0", 2'b01, 1'b0, 1'b1, 8'hA0);

    // t3: run OWN0 out, then last[1] on the 2nd beat of OWN1 hands over at once.
    for (int k = 0; k < 4; k++) tick();
    expect_out("t3_own1_b0", 2'b10, 1'b1, 1'b1, 8'hB1);
    tick();
    last = 2'b10;
    expect_out("t3_own1_b1", 2'b10, 1'b1, 1'b1, 8'hB1);
    tick();
    last = 2'b00;
    expect_out("t3_handover", 2'b01, 1'b0, 1'b1, 8'hA0);

    // t4: stall for 5 cycles after one beat, then 3 remaining beats, then handover.
    do_reset();
    din0 = 8'hA5; req = 2'b11; last = 2'b00; out_ready = 1'b1;
    tick();
    expect_out("t4_beat0", 2'b01, 1'b0, 1'b1, 8'hA5);
    tick();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_out($sformatf("t4_stall_%0d", k), 2'b01, 1'b0, 1'b1, 8'hA5);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expect_out($sformatf("t4_rest_%0d", k), 2'b01, 1'b0, 1'b1, 8'hA5);
      tick();
    end
    expect_out("t4_release", 2'b10, 1'b1, 1'b1, 8'hB1);

    // t5: requester 0 abandons mid-burst. The later tie goes to requester 1 (ptr=0).
    do_reset();
    din0 = 8'h33; req = 2'b01; last = 2'b00;
    tick();
    tick();
    req = 2'b00;
    expect_out("t5_abandon", 2'b01, 1'b0, 1'b0, 8'h33);
    tick();
    expect_out("t5_idle", 2'b00, 1'b0, 1'b0, 8'h33);
    req = 2'b11;
    tick();
    expect_out("t5_tie", 2'b10, 1'b1, 1'b1, 8'hB1);

    // t6: reset while OWN1 holds cnt=2. Requester 0 then wins the first tie.
    do_reset();
    req = 2'b10; last = 2'b00;
    tick();
    expect_out("t6_own1", 2'b10, 1'b1, 1'b1, 8'hB1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("t6_reset", 2'b00, 1'b0, 1'b0, 8'h33);
    req = 2'b11;
    tick();
    expect_out("t6_tie", 2'b01, 1'b0, 1'b1, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
